product_nibble_driver: RTL and testbench

PRODUCT_NIBBLE_DRIVER -- requirements
Module: product_nibble_driver

---
 rtl/product_nibble_driver.sv | 156 +++++++++++++++
 tb/tb_product_nibble_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_nibble_driver.sv
// -----------------------------------------------------------------------------
// product_nibble_driver
//
// Drives an external product unit with a two-nibble operand stream (A, then B),
// waits LATENCY cycles, captures the returned 8-bit product and checks it
// against a locally computed A*B. Each result is presented to a consumer
// through a valid/ready response port. Mismatches are counted in a saturating
// 8-bit error counter.
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous, active-high reset
//   req_valid     operand pair offered
//   req_ready     driver can accept an operand pair (IDLE only)
//   op_a, op_b    multiplicand / multiplier, sampled on acceptance
//   nibble        nibble stream to the product unit (0 when not sending)
//   result_in     product returned by the product unit
//   rsp_valid     response available
//   rsp_ready     response consumer ready
//   rsp_data      last captured result_in
//   rsp_mismatch  last captured value differed from A*B
//   err_count     saturating count of mismatched responses
//   busy          high whenever the FSM is not in IDLE
//
// Parameter
//   LATENCY       WAIT cycles after the B nibble before result_in is sampled
//                 (legal range 1..15)
// -----------------------------------------------------------------------------
module product_nibble_driver #(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  output logic [3:0] nibble,
  input  logic [7:0] result_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_mismatch,
  output logic [7:0] err_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  // Full-width unsigned product: 15*15 = 225 fits in 8 bits, no truncation.
  function automatic logic [7:0] mul_nib(input logic [3:0] a, input logic [3:0] b);
    return {4'b0000, a} * {4'b0000, b};
  endfunction

  // Saturating increment: holds at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] cnt;
  logic       mismatch_now;

  // Compare against the latched operands, never the live op_a/op_b inputs.
  assign mismatch_now = (result_in != mul_nib(a_q, b_q));

  // All outputs are registered; each transition sets the output values that
  // belong to the state being entered, so nibble/req_ready/busy/rsp_valid
  // line up exactly with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      cnt          <= 4'd0;
      nibble       <= 4'd0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'd0;
      rsp_mismatch <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      case (state)
        // ---- IDLE -> SEND_A: latch operands, present A next cycle
        ST_IDLE: begin
          if (req_valid) begin
            a_q       <= op_a;
            b_q       <= op_b;
            nibble    <= op_a;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SEND_A;
          end
        end

        // ---- SEND_A -> SEND_B: A shown for exactly one cycle
        ST_SEND_A: begin
          nibble <= b_q;
          state  <= ST_SEND_B;
        end

        // ---- SEND_B -> WAIT: counter loaded so WAIT lasts LATENCY cycles
        ST_SEND_B: begin
          nibble <= 4'd0;
          cnt    <= WAIT_LOAD;
          state  <= ST_WAIT;
        end

        // ---- WAIT -> RESP: capture result_in on the edge where cnt == 0
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_data     <= result_in;
            rsp_mismatch <= mismatch_now;
            if (mismatch_now) begin
              err_count <= sat_inc(err_count);
            end
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        // ---- RESP -> IDLE: hold response until the consumer takes it
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          nibble    <= 4'd0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_nibble_driver.sv
module tb_product_nibble_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] op_a = 4'd0;
  logic [3:0] op_b = 4'd0;
  logic [3:0] nibble;
  logic [7:0] result_in = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_mismatch;
  logic [7:0] err_count;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  product_nibble_driver #(.LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .nibble       (nibble),
    .result_in    (result_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_mismatch (rsp_mismatch),
    .err_count    (err_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request, then wait (bounded) for rsp_valid without acknowledging.
  task automatic start_and_wait(input logic [3:0] a, input logic [3:0] b, input logic [7:0] res);
    int k;
    op_a      = a;
    op_b      = b;
    result_in = res;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 30) begin
      tick();
      k++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int tot;
    int acc[3];
    int n;
    int t;

    // Asynchronous reset: outputs must be at reset values before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_nibble", 32'(nibble), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_mismatch", 32'(rsp_mismatch), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // 3*5 with cycle-exact timing
    op_a = 4'd3; op_b = 4'd5; result_in = 8'd15; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t1_nib_a", 32'(nibble), 32'd3);
    chk("t1_req_ready_busy", 32'(req_ready), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    op_a = 4'd9; op_b = 4'd1;
    tick();
    chk("t1_nib_b", 32'(nibble), 32'd5);
    tick();
    chk("t1_nib_wait", 32'(nibble), 32'd0);
    chk("t1_vld_w1", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_vld_w2", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_vld", 32'(rsp_valid), 32'd1);
    chk("t1_data", 32'(rsp_data), 32'd15);
    chk("t1_mm", 32'(rsp_mismatch), 32'd0);
    chk("t1_err", 32'(err_count), 32'd0);
    ack();
    chk("t1_vld_drop", 32'(rsp_valid), 32'd0);
    chk("t1_ready_back", 32'(req_ready), 32'd1);
    chk("t1_data_kept", 32'(rsp_data), 32'd15);

    // Boundaries of the product range
    start_and_wait(4'd15, 4'd15, 8'd225);
    chk("t2_data_225", 32'(rsp_data), 32'd225);
    chk("t2_mm_225", 32'(rsp_mismatch), 32'd0);
    ack();
    start_and_wait(4'd0, 4'd9, 8'd0);
    chk("t2_data_0", 32'(rsp_data), 32'd0);
    chk("t2_mm_0", 32'(rsp_mismatch), 32'd0);
    ack();

    // Forced mismatch with backpressure
    start_and_wait(4'd2, 4'd2, 8'd0);
    chk("t3_mm", 32'(rsp_mismatch), 32'd1);
    chk("t3_err", 32'(err_count), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        op_a = 4'd1; op_b = 4'd1; req_valid = 1'b1;
      end
      tick();
      req_valid = 1'b0;
      chk("t3_hold_vld", 32'(rsp_valid), 32'd1);
      chk("t3_hold_data", 32'(rsp_data), 32'd0);
      chk("t3_hold_mm", 32'(rsp_mismatch), 32'd1);
      chk("t3_hold_rdy", 32'(req_ready), 32'd0);
    end
    ack();
    chk("t3_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_ignored_pulse", 32'(busy), 32'd0);
    chk("t3_err_after", 32'(err_count), 32'd1);

    // Saturation: 259 more mismatches, 260 total
    tot = 1;
    for (int i = 0; i < 259; i++) begin
      start_and_wait(4'd1, 4'd1, 8'd0);
      ack();
      tot++;
      if (tot == 254) chk("t4_err_254", 32'(err_count), 32'd254);
      if (tot == 255) chk("t4_err_255", 32'(err_count), 32'd255);
    end
    chk("t4_err_sat", 32'(err_count), 32'd255);

    // Reset during WAIT
    op_a = 4'd7; op_b = 4'd7; result_in = 8'd49; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t5_nibble", 32'(nibble), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_vld", 32'(rsp_valid), 32'd0);
    chk("t5_err", 32'(err_count), 32'd0);
    chk("t5_data", 32'(rsp_data), 32'd0);
    chk("t5_mm", 32'(rsp_mismatch), 32'd0);
    tick();
    tick();
    chk("t5_vld_in_rst", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("t5_vld_after", 32'(rsp_valid), 32'd0);
    start_and_wait(4'd7, 4'd7, 8'd49);
    chk("t5_data_49", 32'(rsp_data), 32'd49);
    chk("t5_mm_49", 32'(rsp_mismatch), 32'd0);
    ack();

    // Back-to-back with req_valid and rsp_ready held high
    op_a = 4'd4; op_b = 4'd6; result_in = 8'd24;
    req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0; t = 0;
    while (t < 60 && n < 3) begin
      if (req_ready) begin
        acc[n] = t;
        n++;
        tick(); t++;
        chk("t6_nib_a", 32'(nibble), 32'd4);
        op_a = 4'hF;
        tick(); t++;
        chk("t6_nib_b", 32'(nibble), 32'd6);
        op_a = 4'd4;
      end else begin
        tick(); t++;
      end
    end
    chk("t6_accepts", 32'(n), 32'd3);
    if (n == 3) begin
      chk("t6_period1", 32'(acc[1] - acc[0]), 32'd6);
      chk("t6_period2", 32'(acc[2] - acc[1]), 32'd6);
    end
    chk("t6_mm", 32'(rsp_mismatch), 32'd0);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rsp_ready = 1'b0;
    chk("t6_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
